// File: rtl/cdr_lock_ctrl.sv
// ---------------------------------------------------------------------------
// cdr_lock_ctrl
//   Acquisition/lock sequencer for the bit clock recovery datapath.
//   Watches per-edge interval measurements and settles on a bit period that
//   drives the recovered-clock divider. Sequence: IDLE -> SEARCH -> TRACK ->
//   LOCKED, with re-acquisition on loss of lock, silence or explicit request.
//
// Ports
//   clk_300M       in   base clock, rising edge
//   rst            in   synchronous reset, active high
//   enable         in   run the controller; low parks it in IDLE
//   force_reacq    in   1-cycle pulse requesting re-acquisition
//   edge_valid     in   1-cycle pulse, edge seen this cycle
//   edge_interval  in   cycles since previous edge, qualified by edge_valid
//   period_out     out  current bit-period estimate
//   period_valid   out  high in TRACK and LOCKED
//   locked         out  high in LOCKED
//   phase_reset    out  1-cycle pulse realigning the recovered-clock counter
//   state          out  IDLE=0 SEARCH=1 TRACK=2 LOCKED=3
//   reacq_count    out  re-acquisition count, saturating at 255
// ---------------------------------------------------------------------------
module cdr_lock_ctrl #(
    parameter int W           = 16,
    parameter int PERIOD_INIT = 801,
    parameter int MIN_PERIOD  = 4,
    parameter int LOCK_EDGES  = 64,
    parameter int TOL_SHIFT   = 3,
    parameter int LOSS_ERRS   = 8,
    parameter int SILENCE_MAX = 65535
) (
    input  logic         clk_300M,
    input  logic         rst,
    input  logic         enable,
    input  logic         force_reacq,
    input  logic         edge_valid,
    input  logic [W-1:0] edge_interval,
    output logic [W-1:0] period_out,
    output logic         period_valid,
    output logic         locked,
    output logic         phase_reset,
    output logic [1:0]   state,
    output logic [7:0]   reacq_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam int CW = $clog2(LOCK_EDGES + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    localparam logic [W-1:0]        P_INIT  = W'(PERIOD_INIT);
    localparam logic [W-1:0]        P_MIN   = W'(MIN_PERIOD);
    localparam logic signed [W:0]   P_MIN_S = (W+1)'(MIN_PERIOD);
    localparam logic [W-1:0]        SIL_MAX = W'(SILENCE_MAX);
    localparam logic [CW-1:0]       LOCK_N  = CW'(LOCK_EDGES);
    localparam logic [EW-1:0]       LOSS_N  = EW'(LOSS_ERRS);

    state_t         state_q, state_d;
    logic [W-1:0]   period_q, period_d;
    logic [CW-1:0]  stable_q, stable_d;
    logic [CW-1:0]  good_q, good_d;
    logic [EW-1:0]  err_q, err_d;
    logic [W-1:0]   idle_q, idle_d;
    logic [7:0]     reacq_q, reacq_d;
    logic           pr_q, pr_d;

    // ---------------------------------------------------------------
    // Edge classification. Everything is compared in W+1 bits so that
    // period + tol cannot wrap.
    // ---------------------------------------------------------------
    logic [W:0]          iv_x, per_x, tol_x, lo_x, hi_x;
    logic signed [W:0]   diff_s, step_s, upd_s;
    logic [W-1:0]        upd_clamped;
    logic                edge_acc, is_short, is_long, in_win, below_per;
    logic                tracking, timeout, loss, restart;

    always_comb begin
        iv_x      = {1'b0, edge_interval};
        per_x     = {1'b0, period_q};
        tol_x     = {1'b0, period_q >> TOL_SHIFT};
        lo_x      = per_x - tol_x;
        hi_x      = per_x + tol_x;
        edge_acc  = edge_valid && (edge_interval >= P_MIN);
        below_per = iv_x < per_x;
        is_short  = iv_x < lo_x;
        is_long   = iv_x > hi_x;
        in_win    = !is_short && !is_long;

        // Quarter-step loop filter toward the measured interval; the
        // arithmetic shift rounds negative corrections toward -inf.
        diff_s = $signed(iv_x) - $signed(per_x);
        step_s = diff_s >>> 2;
        upd_s  = $signed(per_x) + step_s;
        if (upd_s < P_MIN_S)
            upd_clamped = P_MIN;
        else
            upd_clamped = upd_s[W-1:0];
    end

    always_comb begin
        tracking = (state_q == S_TRACK) || (state_q == S_LOCKED);
        // An edge arriving on the threshold cycle keeps the link alive.
        timeout  = tracking && (idle_q == SIL_MAX) && !edge_valid;
        loss     = tracking && edge_acc && is_short && (err_q + EW'(1) == LOSS_N);
        restart  = enable && (force_reacq || timeout || loss);
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_300M) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else if (restart) begin
            state_d = S_SEARCH;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_SEARCH;
                S_SEARCH: if (edge_acc && !below_per && (stable_q + CW'(1) == LOCK_N))
                              state_d = S_TRACK;
                S_TRACK:  if (edge_acc && in_win && (good_q + CW'(1) == LOCK_N))
                              state_d = S_LOCKED;
                S_LOCKED: state_d = S_LOCKED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // ---------------------------------------------------------------
    always_comb begin
        period_valid = (state_q == S_TRACK) || (state_q == S_LOCKED);
        locked       = (state_q == S_LOCKED);
        state        = state_q;
    end

    // ---------------------------------------------------------------
    // Datapath next values
    // ---------------------------------------------------------------
    always_comb begin
        period_d = period_q;
        stable_d = stable_q;
        good_d   = good_q;
        err_d    = err_q;
        reacq_d  = reacq_q;
        pr_d     = 1'b0;
        // Silence counter sees every edge strobe, glitches included.
        if (edge_valid)
            idle_d = '0;
        else if (idle_q == '1)
            idle_d = idle_q;
        else
            idle_d = idle_q + W'(1);

        if (!enable || restart || state_q == S_IDLE) begin
            // Any (re)start: fresh estimate, clean counters. A coincident
            // edge is dropped.
            period_d = P_INIT;
            stable_d = '0;
            good_d   = '0;
            err_d    = '0;
            idle_d   = '0;
            if (restart && reacq_q != 8'hFF)
                reacq_d = reacq_q + 8'd1;
        end else if (edge_acc) begin
            case (state_q)
                S_SEARCH: begin
                    // Shortest interval seen wins; count how long it holds.
                    if (below_per) begin
                        period_d = edge_interval;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + CW'(1);
                        good_d   = '0;
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (is_short) begin
                        err_d = err_q + EW'(1);
                    end else if (in_win) begin
                        err_d    = '0;
                        pr_d     = 1'b1;
                        period_d = upd_clamped;
                        if (good_q != LOCK_N)
                            good_d = good_q + CW'(1);
                    end else begin
                        // Long gap = run of identical bits: realign, but the
                        // interval says nothing reliable about the period.
                        err_d = '0;
                        pr_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_300M) begin
        if (rst) begin
            period_q <= P_INIT;
            stable_q <= '0;
            good_q   <= '0;
            err_q    <= '0;
            idle_q   <= '0;
            reacq_q  <= '0;
            pr_q     <= 1'b0;
        end else begin
            period_q <= period_d;
            stable_q <= stable_d;
            good_q   <= good_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
            reacq_q  <= reacq_d;
            pr_q     <= pr_d;
        end
    end

    assign period_out  = period_q;
    assign phase_reset = pr_q;
    assign reacq_count = reacq_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Scoreboard bench for cdr_lock_ctrl. Each driven cycle pushes the outputs
// expected one clock later; a monitor pops and compares after each edge.
// The silence threshold is shortened so the timeout case stays short.
module tb_cdr_lock_ctrl;

    localparam int W   = 16;
    localparam int SIL = 300;

    logic         clk_300M = 1'b0;
    logic         rst, enable, force_reacq, edge_valid;
    logic [W-1:0] edge_interval;
    logic [W-1:0] period_out;
    logic         period_valid, locked, phase_reset;
    logic [1:0]   state;
    logic [7:0]   reacq_count;

    cdr_lock_ctrl #(.W(W), .SILENCE_MAX(SIL)) dut (
        .clk_300M      (clk_300M),
        .rst           (rst),
        .enable        (enable),
        .force_reacq   (force_reacq),
        .edge_valid    (edge_valid),
        .edge_interval (edge_interval),
        .period_out    (period_out),
        .period_valid  (period_valid),
        .locked        (locked),
        .phase_reset   (phase_reset),
        .state         (state),
        .reacq_count   (reacq_count)
    );

    always #2 clk_300M = ~clk_300M;

    typedef struct {
        string        tag;
        logic [1:0]   st;
        logic [W-1:0] per;
        logic         pr;
        logic [7:0]   rq;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    string        cur_tag;
    logic [1:0]   e_st;
    logic [W-1:0] e_per;
    logic [7:0]   e_rq;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after it.
    task automatic step(input logic ev, input logic [W-1:0] iv, input logic fr,
                        input logic en, input logic e_pr);
        exp_t e;
        @(negedge clk_300M);
        edge_valid    = ev;
        edge_interval = iv;
        force_reacq   = fr;
        enable        = en;
        e.tag = cur_tag;
        e.st  = e_st;
        e.per = e_per;
        e.pr  = e_pr;
        e.rq  = e_rq;
        sb.push_back(e);
    endtask

    task automatic gap();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic edge_in(input logic [W-1:0] iv, input logic e_pr);
        step(1'b1, iv, 1'b0, 1'b1, e_pr);
    endtask

    // From SEARCH at 801: 129 edges of 100 reach LOCKED at period 100.
    task automatic acquire();
        for (int i = 1; i <= 129; i++) begin
            if (i == 1)   e_per = 16'd100;
            if (i == 65)  e_st  = 2'd2;
            if (i == 129) e_st  = 2'd3;
            edge_in(16'd100, i >= 66);
            gap();
        end
    endtask

    always @(posedge clk_300M) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"},  int'(state),        int'(e.st));
            chk({e.tag, ".period"}, int'(period_out),   int'(e.per));
            chk({e.tag, ".pvalid"}, int'(period_valid), int'(e.st >= 2'd2));
            chk({e.tag, ".locked"}, int'(locked),       int'(e.st == 2'd3));
            chk({e.tag, ".phrst"},  int'(phase_reset),  int'(e.pr));
            chk({e.tag, ".reacq"},  int'(reacq_count),  int'(e.rq));
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; force_reacq = 1'b0;
        edge_valid = 1'b0; edge_interval = '0;
        repeat (3) @(negedge clk_300M);
        chk("rst.state",  int'(state),        0);
        chk("rst.period", int'(period_out),   801);
        chk("rst.pvalid", int'(period_valid), 0);
        chk("rst.locked", int'(locked),       0);
        chk("rst.phrst",  int'(phase_reset),  0);
        chk("rst.reacq",  int'(reacq_count),  0);
        rst = 1'b0;

        e_st = 2'd0; e_per = 16'd801; e_rq = 8'd0;
        cur_tag = "idle";
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cur_tag = "en";
        e_st = 2'd1;
        gap();

        // T1: full acquisition at 100
        cur_tag = "T1";
        acquire();

        // T4: loop filter, tolerance boundaries, long interval
        cur_tag = "T4";
        e_per = 16'd102; edge_in(16'd108, 1'b1); gap();
        e_per = 16'd103; edge_in(16'd108, 1'b1); gap();
        edge_in(16'd300, 1'b1); gap();
        e_per = 16'd102; edge_in(16'd100, 1'b1); gap();   // -3>>>2 = -1
        e_per = 16'd99;  edge_in(16'd90,  1'b1); gap();   // exactly per-tol
        e_per = 16'd102; edge_in(16'd111, 1'b1); gap();   // exactly per+tol
        edge_in(16'd89, 1'b0); gap();                     // just short
        edge_in(16'd102, 1'b1); gap();                    // clears error run

        // T3: eight short intervals force re-acquisition
        cur_tag = "T3";
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin e_st = 2'd1; e_per = 16'd801; e_rq = 8'd1; end
            edge_in(16'd50, 1'b0);
            gap();
        end

        // T2: glitches ignored in SEARCH and TRACK
        cur_tag = "T2";
        e_per = 16'd100; edge_in(16'd100, 1'b0); gap();
        edge_in(16'd2, 1'b0); gap();
        edge_in(16'd3, 1'b0); gap();
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) e_st = 2'd2;
            edge_in(16'd100, 1'b0);
            gap();
        end
        edge_in(16'd3, 1'b0); gap();

        // T6: enable drop, then force_reacq with a coincident edge
        cur_tag = "T6";
        e_st = 2'd0; e_per = 16'd801;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        e_st = 2'd1;
        gap();
        e_rq = 8'd2;
        step(1'b1, 16'd50, 1'b1, 1'b1, 1'b0);
        gap();

        // T5: silence timeout
        cur_tag = "T5acq";
        acquire();
        cur_tag = "T5";
        for (int k = 1; k <= SIL - 1; k++) gap();
        e_per = 16'd100; edge_in(16'd100, 1'b1);          // edge on threshold cycle
        for (int k = 1; k <= SIL; k++) gap();
        e_st = 2'd1; e_per = 16'd801; e_rq = 8'd3;
        gap();
        gap();

        // reacq_count saturation
        cur_tag = "sat";
        for (int i = 4; i <= 260; i++) begin
            e_rq = (i > 255) ? 8'd255 : 8'(i);
            step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        end
        gap();

        repeat (3) @(negedge clk_300M);
        chk("sb.drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
